// File: rtl/window_result_frame_writer_if.sv
// Bus between the window-result producer and the frame writer, plus the memory write port.
// valid_i/ready_o: a beat transfers on a rising clk edge where both are high; while valid_i is high
// and ready_o is low, upstream holds data_i stable. ready_o never depends on valid_i.
interface window_result_frame_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  start_i;
  logic                  valid_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ready_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  busy_o;
  logic                  done_o;
  logic [1:0]            state_o;

  modport master (
    output start_i, valid_i, data_i,
    input  ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, state_o
  );

  modport slave (
    input  start_i, valid_i, data_i,
    output ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/window_result_frame_writer.sv
// Writes a full IMG_H x IMG_W frame from the stream of interior 3x3 window results,
// filling the one-pixel border with PAD_VALUE; done_o pulses once per completed frame.
module window_result_frame_writer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    IMG_W      = 8,
  parameter int                    IMG_H      = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input logic                    clk,
  input logic                    rst,
  window_result_frame_writer_if.slave bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]      COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]      ROW_ONE  = ROW_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  border;
  logic                  last_pos;
  logic                  act;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign border   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);

  // act: one position is written this cycle (border always, interior only on a transfer)
  always_comb begin
    state_nxt = state;
    act       = 1'b0;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = RUN;
      RUN: begin
        act = border || bus.valid_i;
        if (act && last_pos) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      addr      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state   <= state_nxt;
      wr_en_q <= act;
      if (state == IDLE && bus.start_i) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end
      if (act) begin
        wr_addr_q <= addr;
        wr_data_q <= border ? PAD_VALUE : bus.data_i;
        addr      <= addr + ADDR_ONE;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
      end
    end
  end

  assign bus.ready_o   = (state == RUN) && !border;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.busy_o    = (state == RUN) || (state == DRAIN);
  assign bus.done_o    = (state == DONE);
  assign bus.state_o   = state;
endmodule

// File: tb/tb_window_result_frame_writer.sv
// Bench for window_result_frame_writer: a 4x4 instance (pad 0) and a 3x3 instance (pad 0xFF),
// directed frames with write/done scoreboards checked by independent monitors.
module tb_window_result_frame_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   xfer_a = 0;
  int   xfer_b = 0;

  // Expected writes: {cycle[15:0], addr[15:0], data[7:0]}
  logic [39:0] exp_q_a[$];
  logic [39:0] exp_q_b[$];
  logic [15:0] done_q_a[$];
  logic [15:0] done_q_b[$];

  window_result_frame_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) if_a ();
  window_result_frame_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) if_b ();

  window_result_frame_writer #(
    .DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .ADDR_WIDTH(16), .PAD_VALUE(8'h00)
  ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

  window_result_frame_writer #(
    .DATA_WIDTH(8), .IMG_W(3), .IMG_H(3), .ADDR_WIDTH(16), .PAD_VALUE(8'hFF)
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit interior4(input int p);
    return (p / 4 > 0) && (p / 4 < 3) && (p % 4 > 0) && (p % 4 < 3);
  endfunction

  // monitors
  always @(negedge clk) begin
    logic [39:0] e;
    logic [15:0] d;
    if (if_a.valid_i && if_a.ready_o) xfer_a++;
    if (if_b.valid_i && if_b.ready_o) xfer_b++;
    if (if_a.wr_en_o) begin
      if (exp_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_a_unexpected: got addr %0h data %0h, expected no write", if_a.wr_addr_o, if_a.wr_data_o);
      end else begin
        e = exp_q_a.pop_front();
        chk("wr_a {cycle,addr,data}", {16'(cyc), if_a.wr_addr_o, if_a.wr_data_o}, e);
      end
    end
    if (if_b.wr_en_o) begin
      if (exp_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_b_unexpected: got addr %0h data %0h, expected no write", if_b.wr_addr_o, if_b.wr_data_o);
      end else begin
        e = exp_q_b.pop_front();
        chk("wr_b {cycle,addr,data}", {16'(cyc), if_b.wr_addr_o, if_b.wr_data_o}, e);
      end
    end
    if (if_a.done_o) begin
      if (done_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_a_spurious: got done at cycle %0d, expected none", cyc);
      end else begin
        d = done_q_a.pop_front();
        chk("done_a_cycle", 16'(cyc), d);
      end
    end
    if (if_b.done_o) begin
      if (done_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_b_spurious: got done at cycle %0d, expected none", cyc);
      end else begin
        d = done_q_b.pop_front();
        chk("done_b_cycle", 16'(cyc), d);
      end
    end
  end

  // driver tasks
  task automatic check_idle_a(input string tag);
    @(negedge clk);
    chk({tag, "_wr_en"},   if_a.wr_en_o,   0);
    chk({tag, "_wr_addr"}, if_a.wr_addr_o, 0);
    chk({tag, "_wr_data"}, if_a.wr_data_o, 0);
    chk({tag, "_ready"},   if_a.ready_o,   0);
    chk({tag, "_busy"},    if_a.busy_o,    0);
    chk({tag, "_done"},    if_a.done_o,    0);
    chk({tag, "_state"},   if_a.state_o,   0);
  endtask

  task automatic frame_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int stall_len, input bit poke_start);
    logic [7:0] beats[4];
    int ia[4];
    int c, pos, idx, stall_left, guard, x0;
    logic [7:0] dv;
    bit adv, xfered;
    beats = '{b0, b1, b2, b3};
    ia = '{5, 6, 9, 10};
    c = cyc;
    x0 = xfer_a;
    for (int a = 0; a < 16; a++) begin
      dv = 8'h00;
      for (int k = 0; k < 4; k++) if (a == ia[k]) dv = beats[k];
      exp_q_a.push_back({16'(c + 2 + a + ((a >= 6) ? stall_len : 0)), 16'(a), dv});
    end
    done_q_a.push_back(16'(c + 18 + stall_len));
    if_a.start_i = 1'b1;
    if_a.valid_i = 1'b1;
    if_a.data_i  = b0;
    @(posedge clk); #1;
    if_a.start_i = 1'b0;
    pos = 0; idx = 0; stall_left = stall_len; guard = 0;
    while (pos < 16 && guard < 64) begin
      guard++;
      @(negedge clk);
      chk($sformatf("ready_a_pos%0d", pos), if_a.ready_o, interior4(pos));
      adv    = !interior4(pos) || if_a.valid_i;
      xfered = interior4(pos) && if_a.valid_i;
      @(posedge clk); #1;
      if (xfered) begin
        idx++;
        if (idx < 4) if_a.data_i = beats[idx];
      end
      if (adv) pos++;
      if (pos == 6 && stall_left > 0) begin
        if_a.valid_i = 1'b0;
        stall_left--;
      end else begin
        if_a.valid_i = 1'b1;
      end
      if (poke_start) if_a.start_i = (pos == 3);
    end
    if (guard >= 64) begin
      checks++; errors++;
      $display("FAIL frame_a_timeout: got pos %0d, expected 16", pos);
    end
    if_a.valid_i = 1'b0;
    if_a.start_i = 1'b0;
    @(negedge clk);
    chk("drain_a_state", if_a.state_o, 2);
    chk("drain_a_busy",  if_a.busy_o,  1);
    @(posedge clk); #1;
    if_a.start_i = poke_start;
    @(negedge clk);
    chk("done_a_state", if_a.state_o, 3);
    chk("done_a_busy",  if_a.busy_o,  0);
    @(posedge clk); #1;
    if_a.start_i = 1'b0;
    @(negedge clk);
    chk("after_done_a_state", if_a.state_o, 0);
    chk("xfers_a", xfer_a - x0, 4);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_a();
    int c;
    c = cyc;
    for (int a = 0; a < 7; a++)
      exp_q_a.push_back({16'(c + 2 + a), 16'(a), (a == 5) ? 8'h11 : ((a == 6) ? 8'h22 : 8'h00)});
    if_a.start_i = 1'b1;
    if_a.valid_i = 1'b1;
    if_a.data_i  = 8'h11;
    @(posedge clk); #1;
    if_a.start_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) if_a.data_i = 8'h22;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_a("midrst_a");
    chk("midrst_a_queue_empty", exp_q_a.size(), 0);
    rst = 1'b0;
    if_a.valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_b();
    int c, guard, x0;
    bit xfered;
    c = cyc;
    x0 = xfer_b;
    for (int a = 0; a < 9; a++)
      exp_q_b.push_back({16'(c + 2 + a), 16'(a), (a == 4) ? 8'h3C : 8'hFF});
    done_q_b.push_back(16'(c + 11));
    if_b.start_i = 1'b1;
    if_b.valid_i = 1'b1;
    if_b.data_i  = 8'h3C;
    @(posedge clk); #1;
    if_b.start_i = 1'b0;
    guard = 0;
    xfered = 1'b0;
    while (!xfered && guard < 20) begin
      guard++;
      @(negedge clk);
      xfered = if_b.valid_i && if_b.ready_o;
      @(posedge clk); #1;
    end
    if_b.valid_i = 1'b0;
    chk("frame_b_xfer_seen", xfered, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("xfers_b", xfer_b - x0, 1);
    chk("idle_b_state", if_b.state_o, 0);
  endtask

  // main sequence
  initial begin
    if_a.start_i = 1'b0; if_a.valid_i = 1'b0; if_a.data_i = 8'h00;
    if_b.start_i = 1'b0; if_b.valid_i = 1'b0; if_b.data_i = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_a("reset_a");
    chk("reset_b_wr_en", if_b.wr_en_o, 0);
    chk("reset_b_state", if_b.state_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    frame_a(8'hA1, 8'hA2, 8'hA3, 8'hA4, 0, 1'b0);
    frame_a(8'hA1, 8'hA2, 8'hA3, 8'hA4, 3, 1'b0);
    frame_a(8'h55, 8'h55, 8'h55, 8'h55, 0, 1'b0);
    reset_mid_a();
    frame_a(8'hB1, 8'hB2, 8'hB3, 8'hB4, 0, 1'b1);
    frame_a(8'hC1, 8'hC2, 8'hC3, 8'hC4, 0, 1'b0);
    frame_b();

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_a_drained",  exp_q_a.size(),  0);
    chk("exp_q_b_drained",  exp_q_b.size(),  0);
    chk("done_q_a_drained", done_q_a.size(), 0);
    chk("done_q_b_drained", done_q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // final report if the sequence never completes
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no completion by cycle %0d, expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_result_frame_writer.md
# window_result_frame_writer

Output-side counterpart of the 3x3 window buffer. It accepts the stream of per-window results (one result per interior pixel, (IMG_H-2)*(IMG_W-2) results per frame, raster order) and writes a full IMG_H x IMG_W frame to an output memory port. The block inserts PAD_VALUE for the one-pixel border that the 3x3 window cannot produce. It signals frame completion with a single-cycle done pulse.

## Interface
- DATA_WIDTH, 8, result/pixel width
- IMG_W, 8, frame width in pixels (>= 3)
- IMG_H, 8, frame height in pixels (>= 3)
- ADDR_WIDTH, 16, write address width (must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H)
- PAD_VALUE, 0, value written at border positions
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  frame start pulse; honoured only in IDLE
- valid_i  in  1  result beat valid
- data_i  in  DATA_WIDTH  result value
- ready_o  out  1  block can accept a result this cycle; transfer = valid_i & ready_o
- wr_en_o  out  1  memory write strobe (registered)
- wr_addr_o  out  ADDR_WIDTH  write address (registered)
- wr_data_o  out  DATA_WIDTH  write data (registered)
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DRAIN when the action at the last position (IMG_H-1, IMG_W-1) occurs.
  - DRAIN -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Position counters row (0..IMG_H-1), col (0..IMG_W-1), and linear address addr (0..IMG_W*IMG_H-1). All are cleared on entry to RUN.
- Border position: row==0, row==IMG_H-1, col==0 or col==IMG_W-1. All other positions are interior.
- In RUN, at a border position: write PAD_VALUE at addr and advance. No input is consumed and ready_o = 0.
- In RUN, at an interior position: ready_o = 1.
  - On valid_i: write data_i at addr and advance.
  - Without valid_i: stall, with no write and no advance.
- Advance: col+1; when col==IMG_W-1, col wraps to 0 and row+1. addr always +1.
- ready_o is combinational from state and the registered position. It is 0 in IDLE, DRAIN and DONE.
- valid_i while ready_o=0 is not a transfer. Upstream holds data_i until accepted.
- start_i in RUN, DRAIN or DONE is ignored. No frame queuing.
- Frame totals: exactly IMG_W*IMG_H writes to consecutive addresses 0..IMG_W*IMG_H-1, and exactly (IMG_H-2)*(IMG_W-2) input transfers.
- Degenerate IMG_W=IMG_H=3: one interior position, at addr 4.
- Reset mid-frame abandons the frame. No done_o is produced for it, and the next start_i restarts from addr 0.

## Timing
- Reset values: state IDLE, ready_o 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, busy_o 0, done_o 0, counters 0.
- start_i high at cycle 0: RUN at cycle 1, ready_o still 0 (position 0,0 is border).
- An action at cycle t appears as wr_en_o=1 with its addr/data at cycle t+1. Latency is 1.
- wr_en_o is 0 in any cycle following a stall or a non-RUN cycle.
- Last action at cycle t: wr_en_o for the last address at t+1 (state DRAIN). done_o=1 and busy_o=0 at t+2 (state DONE). IDLE at t+3.
- With no stalls, RUN lasts exactly IMG_W*IMG_H cycles.
- A start_i in the DONE cycle is ignored. A start_i at t+3 or later is accepted.

## Test plan
- IMG_W=IMG_H=4, start at cycle 0, valid_i always 1 with data 0xA1,0xA2,0xA3,0xA4:
  - wr_en_o at cycles 2..17, addr 0..15.
  - addr 5,6,9,10 carry 0xA1..0xA4; all others 0.
  - done_o only at cycle 18.
- Same frame, valid_i dropped for 3 cycles at interior position addr 6:
  - ready_o stays 1 for those cycles, no wr_en_o, addr not advanced.
  - Resumes with 0xA2 at addr 6.
  - done_o delayed by exactly 3 cycles.
- valid_i held 1 with data 0x55 from cycle 0:
  - ready_o 0 at all border positions, and the 0x55 beat is not consumed there.
  - First transfer occurs only at addr 5.
- Reset mid-frame:
  - rst asserted after 7 writes: all outputs 0 and state IDLE the next cycle.
  - A new start_i produces writes from addr 0, and there is no spurious done_o.
- IMG_W=IMG_H=3, PAD_VALUE=0xFF, single beat 0x3C: 9 writes; addr 4 = 0x3C, rest 0xFF; exactly one transfer.
- start_i pulsed during RUN and during DONE: ignored, with no counter reset and a single done_o. A start_i two cycles after done_o begins a new frame.
